// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Multi-cycle 32-bit signed multiply / divide sequencer that
//               borrows the shared execute-stage ALU for every add and
//               subtract. Sign handling, carry/borrow recovery and partial
//               register shifting are done locally.
//               Optional divide support: define MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NEGA  = 3'd1;
    localparam logic [2:0] S_NEGB  = 3'd2;
    localparam logic [2:0] S_MITER = 3'd3;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] S_DITER = 3'd4;
`endif
    localparam logic [2:0] S_SIGN  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [4:0]  c_ALU_ADD  = 5'd0;
    localparam logic [4:0]  c_ALU_SUB  = 5'd1;
    localparam logic [4:0]  c_CNT_LAST = 5'd31;
    localparam logic [31:0] c_INT_MIN  = 32'h8000_0000;

    logic [2:0]  r_state;
    logic        r_is_div;
    logic        r_neg;
    logic [31:0] r_a_mag;   // raw A until NEGA, then |A|
    logic [31:0] r_b_mag;   // raw B until NEGB, then |B|
    logic [31:0] r_hi;      // product high word / division remainder
    logic [31:0] r_lo;      // product low word (multiplier) / quotient
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;

    // Multiply step: ALU forms hi + |A|; the carry out is rebuilt from MSBs
    logic [31:0] w_mul_sum;
    logic        w_mul_carry;
    logic        w_mul_exc;
    logic [31:0] w_b_abs;

    assign w_mul_carry = r_lo[0] &
                         ((r_hi[31] & r_a_mag[31]) |
                          ((r_hi[31] | r_a_mag[31]) & ~alu_result[31]));
    assign w_mul_sum   = r_lo[0] ? alu_result : r_hi;
    // INT_MIN is representable only when the product is negative
    assign w_mul_exc   = (r_hi != 32'd0) ||
                         (r_lo[31] && !(r_neg && (r_lo == c_INT_MIN)));
    assign w_b_abs     = r_b_mag[31] ? alu_result : r_b_mag;

`ifdef MULDIV_DIV_EN
    // Divide step: remainder shifted left with next dividend bit, minus |B|
    logic [31:0] w_rshift;
    logic        w_borrow;
    logic        w_div_exc;

    assign w_rshift  = {r_hi[30:0], r_lo[31]};
    assign w_borrow  = (~w_rshift[31] & r_b_mag[31]) |
                       ((~w_rshift[31] | r_b_mag[31]) & alu_result[31]);
    // Only MIN / -1 produces a positive quotient of 2^31
    assign w_div_exc = (r_a_mag == c_INT_MIN) && (r_b_mag == 32'd1) && !r_neg;
`endif

    assign busy           = (r_state != S_IDLE);
    assign alu_shiftamt   = 5'd0;
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

    // ALU operand/opcode selection, purely from registered state
    always_comb begin
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_opcode   = c_ALU_ADD;
        case (r_state)
            S_NEGA: begin
                alu_operandB = r_a_mag;
                alu_opcode   = c_ALU_SUB;
            end
            S_NEGB: begin
                alu_operandB = r_b_mag;
                alu_opcode   = c_ALU_SUB;
            end
            S_MITER: begin
                alu_operandA = r_hi;
                alu_operandB = r_a_mag;
                alu_opcode   = c_ALU_ADD;
            end
`ifdef MULDIV_DIV_EN
            S_DITER: begin
                alu_operandA = w_rshift;
                alu_operandB = r_b_mag;
                alu_opcode   = c_ALU_SUB;
            end
`endif
            S_SIGN: begin
                alu_operandB = r_lo;
                alu_opcode   = c_ALU_SUB;
            end
            default: begin
                alu_operandA = 32'd0;
                alu_operandB = 32'd0;
                alu_opcode   = c_ALU_ADD;
            end
        endcase
    end

    // Sequencer state, partial registers and registered result outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_a_mag  <= 32'd0;
            r_b_mag  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        r_is_div <= ~ctrl_MULT;
                        r_a_mag  <= data_operandA;
                        r_b_mag  <= data_operandB;
                        r_neg    <= data_operandA[31] ^ data_operandB[31];
                        r_state  <= S_NEGA;
                    end
                end
                S_NEGA: begin
                    r_a_mag <= r_a_mag[31] ? alu_result : r_a_mag;
                    r_state <= S_NEGB;
`ifndef MULDIV_DIV_EN
                    // Divide is not built: report it as an exception at once
                    if (r_is_div) begin
                        r_result <= 32'd0;
                        r_exc    <= 1'b1;
                        r_rdy    <= 1'b1;
                        r_state  <= S_DONE;
                    end
`endif
                end
                S_NEGB: begin
                    r_b_mag <= w_b_abs;
                    r_hi    <= 32'd0;
                    r_lo    <= r_is_div ? r_a_mag : w_b_abs;
                    r_cnt   <= 5'd0;
                    if (!r_is_div) begin
                        r_state <= S_MITER;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (r_b_mag == 32'd0) begin
                            r_result <= 32'd0;
                            r_exc    <= 1'b1;
                            r_rdy    <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_DITER;
                        end
`else
                        r_result <= 32'd0;
                        r_exc    <= 1'b1;
                        r_rdy    <= 1'b1;
                        r_state  <= S_DONE;
`endif
                    end
                end
                S_MITER: begin
                    r_hi  <= {w_mul_carry, w_mul_sum[31:1]};
                    r_lo  <= {w_mul_sum[0], r_lo[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_SIGN;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DITER: begin
                    r_hi  <= w_borrow ? w_rshift : alu_result;
                    r_lo  <= {r_lo[30:0], ~w_borrow};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_SIGN;
                    end
                end
`endif
                S_SIGN: begin
`ifdef MULDIV_DIV_EN
                    if (r_is_div ? w_div_exc : w_mul_exc) begin
`else
                    if (w_mul_exc) begin
`endif
                        r_result <= 32'd0;
                        r_exc    <= 1'b1;
                    end else begin
                        r_result <= r_neg ? alu_result : r_lo;
                        r_exc    <= 1'b0;
                    end
                    r_rdy   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Scoreboard bench for alu_muldiv_seq with a behavioural ALU.
//               Stimulus pushes expected results; a monitor checks each ready
//               pulse for value, exception flag and arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   idle_pend = 1'b0;
    int   idle_cyc = 0;

    alu_muldiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Shared ALU stand-in: 0 = add, 1 = subtract
    always_comb begin
        if (alu_opcode == 5'd1) alu_result = alu_operandA - alu_operandB;
        else                    alu_result = alu_operandA + alu_operandB;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ALU opcode/shift legality, every cycle
    always @(negedge clock) begin
        assert (alu_opcode <= 5'd1 && alu_shiftamt == 5'd0)
        else begin
            n_fail++;
            $display("FAIL alu_ctrl: opcode %0d shiftamt %0d", alu_opcode, alu_shiftamt);
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        exp_t e;
        if (idle_pend && cyc == idle_cyc) begin
            idle_pend = 1'b0;
            check_val("busy_low_after_done", {31'd0, busy}, 32'd0);
            check_val("rdy_single_pulse", {31'd0, data_resultRDY}, 32'd0);
        end
        if (!reset && data_resultRDY && !idle_pend) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rdy: result 0x%08h at cycle %0d, none expected", data_result, cyc);
            end else begin
                e = sb.pop_front();
                check_val("result", data_result, e.res);
                check_val("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check_val("rdy_cycle", cyc, e.cyc);
                idle_pend = 1'b1;
                idle_cyc  = cyc + 1;
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input logic [31:0] er, input logic ee);
        exp_t e;
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        e.res = er;
        e.exc = ee;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input bit scramble);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clock);
            n++;
            if (scramble) begin
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d results outstanding, busy %0d", sb.size(), busy);
            sb.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] er, input logic ee);
        start_op(m, d, a, b, lat, er, ee);
        wait_done(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (3) @(negedge clock);
        check_val("rst_result", data_result, 32'd0);
        check_val("rst_exc", {31'd0, data_exception}, 32'd0);
        check_val("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_alu_a", alu_operandA, 32'd0);
        check_val("rst_alu_b", alu_operandB, 32'd0);
        check_val("rst_alu_op", {27'd0, alu_opcode}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Multiply vectors
        run_op(1, 0, 32'd7,         32'hFFFF_FFFA, 35, 32'hFFFF_FFD6, 0); // 7 * -6
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 35, 32'd0,        1); // 2^32
        run_op(1, 0, 32'h8000_0000, 32'd1,         35, 32'h8000_0000, 0); // MIN * 1
        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0,        1); // MIN * -1
        run_op(1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 35, 32'd15,       0); // -3 * -5
        run_op(1, 0, 32'h7FFF_FFFF, 32'd2,         35, 32'd0,        1); // overflow into bit 31
        run_op(1, 0, 32'hFFFF_0000, 32'h0000_8000, 35, 32'h8000_0000, 0); // -2^16 * 2^15
        run_op(1, 0, 32'd0,         32'hFFFF_FFFB, 35, 32'd0,        0); // 0 * -5

        // Operands scrambled every cycle after the start edge
        start_op(1, 0, 32'd1234, 32'hFFFF_FFFE, 35, 32'hFFFF_F65C, 0); // 1234 * -2
        wait_done(1'b1);

`ifdef MULDIV_DIV_EN
        run_op(0, 1, 32'hFFFF_FF9C, 32'd7,         35, 32'hFFFF_FFF2, 0); // -100 / 7
        run_op(0, 1, 32'd100,       32'hFFFF_FFF9, 35, 32'hFFFF_FFF2, 0); // 100 / -7
        run_op(0, 1, 32'd5,         32'd0,         2,  32'd0,        1); // divide by zero
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0,        1); // MIN / -1
        run_op(0, 1, 32'h8000_0000, 32'd1,         35, 32'h8000_0000, 0); // MIN / 1
        run_op(0, 1, 32'd7,         32'd100,       35, 32'd0,        0); // 7 / 100
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2,         35, 32'hFFFF_FFFD, 0); // -7 / 2
`else
        run_op(0, 1, 32'hFFFF_FF9C, 32'd7, 1, 32'd0, 1);
        run_op(0, 1, 32'd5,         32'd0, 1, 32'd0, 1);
`endif

        // Both starts high: multiply wins; second start while busy ignored
        start_op(1, 1, 32'd3, 32'd4, 35, 32'd12, 0);
        repeat (9) @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_done(1'b0);
        repeat (40) @(negedge clock);
        check_val("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a multiply
        start_op(1, 0, 32'd11, 32'd13, 35, 32'd143, 0);
        repeat (17) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check_val("abort_result", data_result, 32'd0);
        check_val("abort_alu_a", alu_operandA, 32'd0);
        check_val("abort_alu_b", alu_operandB, 32'd0);
        check_val("abort_alu_op", {27'd0, alu_opcode}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check_val("post_abort_idle", {31'd0, busy}, 32'd0);
        run_op(1, 0, 32'd2, 32'd3, 35, 32'd6, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
